// File: rtl/writeback_queue.sv
// Writeback queue: accepts up to two in-order register writes per cycle, buffers them
// in a circular queue, drains one per cycle into an 8 x 16 register file, and forwards.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb0_valid,
    input  logic [REG_AW-1:0]         wb0_reg,
    input  logic [DATA_W-1:0]         wb0_data,
    input  logic                      wb1_valid,
    input  logic [REG_AW-1:0]         wb1_reg,
    input  logic [DATA_W-1:0]         wb1_data,
    output logic                      wb_stall,
    input  logic [REG_AW-1:0]         rd_a_addr,
    output logic [DATA_W-1:0]         rd_a_data,
    input  logic [REG_AW-1:0]         rd_b_addr,
    output logic [DATA_W-1:0]         rd_b_data,
    output logic [(1<<REG_AW)-1:0]    pending,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << REG_AW;

    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] regfile_q [NREG];

    logic [REG_AW-1:0] q_reg_q  [DEPTH];
    logic [DATA_W-1:0] q_data_q [DEPTH];

    logic          lane0_en, lane1_en, deq;
    logic [1:0]    enq_n;
    logic [PW-1:0] lane1_idx;

    // Stall depends only on registered occupancy, so no input-to-stall path exists.
    assign wb_stall = (count_q >= CW'(DEPTH - 1));
    assign count    = count_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        lane0_en  = wb0_valid && !wb_stall;
        lane1_en  = wb1_valid && !wb_stall;
        deq       = (count_q != '0);
        enq_n     = {1'b0, lane0_en} + {1'b0, lane1_en};
        lane1_idx = lane0_en ? tail_q + PW'(1) : tail_q;
        tail_d    = tail_q + PW'(enq_n);
        head_d    = head_q + PW'(deq);
        count_d   = count_q + CW'(enq_n) - CW'(deq);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                regfile_q[r] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (deq) begin
                regfile_q[q_reg_q[head_q]] <= q_data_q[head_q];
            end
        end
    end

    // NOTE: queue storage is not reset; entries are only meaningful below count_q, so a flush clears pointers alone.
    always_ff @(posedge clk) begin
        if (lane0_en) begin
            q_reg_q[tail_q]  <= wb0_reg;
            q_data_q[tail_q] <= wb0_data;
        end
        if (lane1_en) begin
            q_reg_q[lane1_idx]  <= wb1_reg;
            q_data_q[lane1_idx] <= wb1_data;
        end
    end

    // Oldest-to-youngest walk; a later match overwrites, leaving the youngest value.
    function automatic logic [DATA_W-1:0] lookup(input logic [REG_AW-1:0] addr);
        logic [DATA_W-1:0] val;
        logic [PW-1:0]     idx;
        val = regfile_q[addr];
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (q_reg_q[idx] == addr)) begin
                val = q_data_q[idx];
            end
        end
        return val;
    endfunction

    always_comb begin
        rd_a_data = lookup(rd_a_addr);
        rd_b_data = lookup(rd_b_addr);
    end

    always_comb begin
        logic [PW-1:0] idx;
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                pending[q_reg_q[idx]] = 1'b1;
            end
        end
    end

endmodule
